data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed 32-bit data memory with a fixed number of stall cycles per access
// and byte-lane writes. Define DMEM_ERR_EN to flag and suppress out-of-range accesses.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [3:0]  byte_select_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    logic [31:0]   r_mem [DEPTH_WORDS];
    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_data;

    logic          w_req;
    logic          w_rd_only;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic [31:0]   w_rdata;
    logic          w_complete;
    logic          w_mem_we;
    logic          w_unused_bits;

    assign w_req     = rd_i | wr_i;
    assign w_rd_only = rd_i & ~wr_i;
    assign w_idx     = addr_i[AW+1:2];
    assign w_rdata   = r_mem[w_idx];
    assign w_unused_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_ERR_EN
    assign w_oor = ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));
`else
    assign w_oor = 1'b0;
`endif

    // Completion: the request cycle itself without stalls, otherwise the ACK cycle.
    assign w_complete = (WAIT_STATES == 0) ? (~rst_i & w_req)
                                           : (~rst_i & (r_state == ST_ACK));
    assign w_mem_we   = w_complete & wr_i & ~w_oor;

    // Access sequencing: stall counter and read-data holding register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_data  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_data <= 32'd0;
                    if (w_req && (WAIT_STATES > 0)) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!w_req) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_data  <= w_rd_only ? (w_oor ? ERR_WORD : w_rdata) : 32'd0;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    r_data  <= 32'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt   <= 4'd0;
                    r_data  <= 32'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < 4; n++) begin
            if (w_mem_we && byte_select_i[n]) begin
                r_mem[w_idx][8*n +: 8] <= data_i[8*n +: 8];
            end
        end
    end

    // Handshake outputs; data_o is zero outside a read completion.
    always_comb begin
        ready_o = 1'b0;
        data_o  = 32'd0;
        err_o   = 1'b0;
        if (rst_i) begin
            ready_o = 1'b0;
        end else if (WAIT_STATES == 0) begin
            ready_o = 1'b1;
            err_o   = w_complete & w_oor;
            if (w_rd_only) begin
                data_o = w_oor ? ERR_WORD : w_rdata;
            end else begin
                data_o = 32'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: ready_o = ~w_req;
                ST_WAIT: ready_o = 1'b0;
                ST_ACK: begin
                    ready_o = 1'b1;
                    data_o  = r_data;
                    err_o   = w_oor;
                end
                default: ready_o = 1'b0;
            endcase
        end
    end

endmodule
